alu_decode_stage: RTL and testbench

Registered instruction-decode stage that generates the 4-bit `alu_ctrl` code, operand selects and immediate consumed by the RV32I ALU. It sits between fetch and execute, holds one decoded instruction in an output register, and moves data using valid/ready handshakes on both sides with a synchronous flush for branch redirect. It is the producer end of the ALU control interface.

---
 rtl/alu_decode_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// ----------------
// Registered RV32I decode stage feeding the ALU. One decoded instruction is
// held in an output register; valid/ready handshakes on both sides, with a
// synchronous flush that drops the held beat and blocks capture.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   flush               drop held beat, no capture this cycle
//   in_valid/in_ready   fetch side handshake (instr, pc)
//   out_valid/out_ready execute side handshake
//   alu_ctrl            ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6,
//                       SRA 7, SLT 8, SLTU 9
//   op_a_sel            00 rs1, 01 pc, 10 zero
//   op_b_sel            0 rs2, 1 imm
//   imm                 sign-extended immediate
//   rs1, rs2, rd        register indices
//   reg_write, mem_read, mem_write, branch   class flags
//   pc_out              registered pc
//   illegal             unsupported encoding
//
// Build option: ALU_DEC_ILLEGAL_EN. When defined, `illegal` is registered with
// the beat. When undefined, `illegal` is tied to 0. In both builds an
// unsupported encoding decodes as a NOP-like ADD with every class flag clear.

module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  op_a_sel,
  output logic        op_b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic [31:0] pc_out,
  output logic        illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [3:0]  alu_base;

  logic [3:0]  alu_ctrl_next;
  logic [1:0]  op_a_sel_next;
  logic        op_b_sel_next;
  logic [31:0] imm_next;
  logic        reg_write_next;
  logic        mem_read_next;
  logic        mem_write_next;
  logic        branch_next;
  logic        illegal_next;

  logic        capture;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};

  // in_ready is combinational from out_ready so a consumed beat can be
  // replaced in the same cycle (full throughput).
  assign in_ready = rst_n & ~flush & (~out_valid | out_ready);
  assign capture  = in_valid & in_ready;

  // funct3 map shared by OP and OP-IMM; SUB is layered on for OP only.
  always_comb begin
    alu_base = ALU_ADD;
    case (funct3)
      3'b000:  alu_base = ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  end

  always_comb begin
    alu_ctrl_next  = ALU_ADD;
    op_a_sel_next  = 2'b00;
    op_b_sel_next  = 1'b0;
    imm_next       = 32'h0;
    reg_write_next = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    branch_next    = 1'b0;
    illegal_next   = 1'b0;

    case (opcode)
      OPC_OP: begin
        reg_write_next = 1'b1;
        alu_ctrl_next  = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : alu_base;
        // 0x20 is only meaningful as the SUB / SRA selector.
        if (funct7 != 7'h00 &&
            !(funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
          illegal_next = 1'b1;
      end
      OPC_OP_IMM: begin
        op_b_sel_next  = 1'b1;
        reg_write_next = 1'b1;
        imm_next       = imm_i;
        alu_ctrl_next  = alu_base;
        // Only the shift forms constrain the upper immediate bits.
        if (funct3 == 3'b001 && funct7 != 7'h00)
          illegal_next = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
          illegal_next = 1'b1;
      end
      OPC_LUI: begin
        op_a_sel_next  = 2'b10;
        op_b_sel_next  = 1'b1;
        imm_next       = imm_u;
        reg_write_next = 1'b1;
      end
      OPC_AUIPC: begin
        op_a_sel_next  = 2'b01;
        op_b_sel_next  = 1'b1;
        imm_next       = imm_u;
        reg_write_next = 1'b1;
      end
      OPC_LOAD: begin
        op_b_sel_next  = 1'b1;
        imm_next       = imm_i;
        mem_read_next  = 1'b1;
        reg_write_next = 1'b1;
      end
      OPC_STORE: begin
        op_b_sel_next  = 1'b1;
        imm_next       = imm_s;
        mem_write_next = 1'b1;
      end
      OPC_BRANCH: begin
        branch_next = 1'b1;
        imm_next    = imm_b;
        case (funct3[2:1])
          2'b00:   alu_ctrl_next = ALU_SUB;
          2'b10:   alu_ctrl_next = ALU_SLT;
          2'b11:   alu_ctrl_next = ALU_SLTU;
          default: illegal_next  = 1'b1;
        endcase
      end
      default: illegal_next = 1'b1;
    endcase

    // Unsupported encodings collapse to a harmless ADD with no side effects.
    if (illegal_next) begin
      alu_ctrl_next  = ALU_ADD;
      op_a_sel_next  = 2'b00;
      op_b_sel_next  = 1'b0;
      imm_next       = 32'h0;
      reg_write_next = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      branch_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_ctrl  <= 4'h0;
      op_a_sel  <= 2'b00;
      op_b_sel  <= 1'b0;
      imm       <= 32'h0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      pc_out    <= 32'h0;
    end else begin
      // Flush wins; a held beat that is consumed in the flush cycle is
      // simply gone either way.
      if (flush)
        out_valid <= 1'b0;
      else if (capture)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      if (capture) begin
        alu_ctrl  <= alu_ctrl_next;
        op_a_sel  <= op_a_sel_next;
        op_b_sel  <= op_b_sel_next;
        imm       <= imm_next;
        rs1       <= instr[19:15];
        rs2       <= instr[24:20];
        rd        <= instr[11:7];
        reg_write <= reg_write_next;
        mem_read  <= mem_read_next;
        mem_write <= mem_write_next;
        branch    <= branch_next;
        pc_out    <= pc;
      end
    end
  end

`ifdef ALU_DEC_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal <= 1'b0;
    else if (capture)
      illegal <= illegal_next;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [1:0]  op_a_sel;
  logic        op_b_sel;
  logic [31:0] imm;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic [31:0] pc_out;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a_sel  (op_a_sel),
    .op_b_sel  (op_b_sel),
    .imm       (imm),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .pc_out    (pc_out),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Drive one beat with out_ready high; returns #1 after the capture edge.
  task automatic send_beat(input logic [31:0] i, input logic [31:0] p);
    @(negedge clk);
    in_valid  = 1'b1;
    instr     = i;
    pc        = p;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("beat instr=%08h pc=%08h -> valid=%0b alu=%0d a=%0d b=%0b imm=%08h rd=%0d flags=%0b%0b%0b%0b ill=%0b",
             i, p, out_valid, alu_ctrl, op_a_sel, op_b_sel, imm, rd,
             reg_write, mem_read, mem_write, branch, illegal);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    instr = 32'h002081B3; pc = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_alu_ctrl got %0h exp 0", alu_ctrl); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %08h exp 0", pc_out); end
    checks++; if (rd !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_fields got rd=%0d rw=%0b ill=%0b exp 0", rd, reg_write, illegal); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_add;
    send_beat(32'h002081B3, 32'h0000_0100);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %0b exp 1", out_valid); end
    checks++; if (alu_ctrl !== 4'b0000) begin errors++; $display("FAIL add_alu_ctrl got %0h exp 0", alu_ctrl); end
    checks++; if (rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd3) begin
      errors++; $display("FAIL add_regs got %0d,%0d,%0d exp 1,2,3", rs1, rs2, rd); end
    checks++; if (op_b_sel !== 1'b0 || reg_write !== 1'b1) begin
      errors++; $display("FAIL add_sel_rw got b=%0b rw=%0b exp 0,1", op_b_sel, reg_write); end
    checks++; if (pc_out !== 32'h0000_0100) begin errors++; $display("FAIL add_pc_out got %08h exp 00000100", pc_out); end
  endtask

  task automatic test_op_map;
    logic [31:0] vec [10];
    logic [3:0]  exp [10];
    vec = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3,
            32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3};
    exp = '{4'd0, 4'd1, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd7, 4'd3, 4'd2};
    for (int k = 0; k < 10; k++) begin
      send_beat(vec[k], 32'h0000_1000 + 32'(k * 4));
      checks++; if (alu_ctrl !== exp[k]) begin
        errors++; $display("FAIL op_map[%0d] alu_ctrl got %0h exp %0h", k, alu_ctrl, exp[k]); end
    end
  endtask

  task automatic test_srai;
    send_beat(32'h40335293, 32'h0000_0200);
    checks++; if (alu_ctrl !== 4'b0111) begin errors++; $display("FAIL srai_alu_ctrl got %0h exp 7", alu_ctrl); end
    checks++; if (imm !== 32'h0000_0403) begin errors++; $display("FAIL srai_imm got %08h exp 00000403", imm); end
    checks++; if (op_b_sel !== 1'b1 || rd !== 5'd5) begin
      errors++; $display("FAIL srai_sel_rd got b=%0b rd=%0d exp 1,5", op_b_sel, rd); end
  endtask

  task automatic test_upper;
    send_beat(32'h123450B7, 32'h0000_0300);
    checks++; if (alu_ctrl !== 4'b0000 || op_a_sel !== 2'b10) begin
      errors++; $display("FAIL lui_ctrl got alu=%0h a=%0d exp 0,2", alu_ctrl, op_a_sel); end
    checks++; if (imm !== 32'h1234_5000) begin errors++; $display("FAIL lui_imm got %08h exp 12345000", imm); end
    send_beat(32'h12345097, 32'h0000_0304);
    checks++; if (op_a_sel !== 2'b01 || op_b_sel !== 1'b1 || reg_write !== 1'b1) begin
      errors++; $display("FAIL auipc_sel got a=%0d b=%0b rw=%0b exp 1,1,1", op_a_sel, op_b_sel, reg_write); end
  endtask

  task automatic test_mem;
    // lw x5, -4(x2)
    send_beat(32'hFFC12283, 32'h0000_0400);
    checks++; if (imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL load_imm got %08h exp fffffffc", imm); end
    checks++; if (mem_read !== 1'b1 || reg_write !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL load_flags got mr=%0b rw=%0b mw=%0b exp 1,1,0", mem_read, reg_write, mem_write); end
    // sw x5, 8(x2)
    send_beat(32'h00512423, 32'h0000_0404);
    checks++; if (imm !== 32'h0000_0008) begin errors++; $display("FAIL store_imm got %08h exp 00000008", imm); end
    checks++; if (mem_write !== 1'b1 || reg_write !== 1'b0 || op_b_sel !== 1'b1) begin
      errors++; $display("FAIL store_flags got mw=%0b rw=%0b b=%0b exp 1,0,1", mem_write, reg_write, op_b_sel); end
  endtask

  task automatic test_branch;
    logic [31:0] vec [4];
    logic [3:0]  exp [4];
    vec = '{32'h00208063, 32'h00209063, 32'h0020C063, 32'h0020F063};
    exp = '{4'd1, 4'd1, 4'd8, 4'd9};
    for (int k = 0; k < 4; k++) begin
      send_beat(vec[k], 32'h0000_0500 + 32'(k * 4));
      checks++; if (alu_ctrl !== exp[k] || branch !== 1'b1 || op_b_sel !== 1'b0 || reg_write !== 1'b0) begin
        errors++; $display("FAIL branch[%0d] got alu=%0h br=%0b b=%0b rw=%0b exp %0h,1,0,0",
                           k, alu_ctrl, branch, op_b_sel, reg_write, exp[k]); end
    end
  endtask

  task automatic test_illegal;
    logic exp_ill;
`ifdef ALU_DEC_ILLEGAL_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    send_beat(32'hFFFFFFFF, 32'h0000_0600);
    checks++; if (illegal !== exp_ill) begin errors++; $display("FAIL ill_ffff got %0b exp %0b", illegal, exp_ill); end
    checks++; if (out_valid !== 1'b1 || alu_ctrl !== 4'h0 || reg_write !== 1'b0 || mem_read !== 1'b0 ||
                  mem_write !== 1'b0 || branch !== 1'b0) begin
      errors++; $display("FAIL ill_ffff_nop got v=%0b alu=%0h rw=%0b mr=%0b mw=%0b br=%0b exp 1,0,0,0,0,0",
                         out_valid, alu_ctrl, reg_write, mem_read, mem_write, branch); end
    // and with funct7=0x20 is not a valid OP encoding
    send_beat(32'h4020F1B3, 32'h0000_0604);
    checks++; if (illegal !== exp_ill || alu_ctrl !== 4'h0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL ill_and20 got ill=%0b alu=%0h rw=%0b exp %0b,0,0", illegal, alu_ctrl, reg_write, exp_ill); end
    // branch funct3 010 is unassigned
    send_beat(32'h0020A063, 32'h0000_0608);
    checks++; if (illegal !== exp_ill || branch !== 1'b0) begin
      errors++; $display("FAIL ill_br010 got ill=%0b br=%0b exp %0b,0", illegal, branch, exp_ill); end
    // a legal beat after an illegal one clears the flag
    send_beat(32'h002081B3, 32'h0000_060C);
    checks++; if (illegal !== 1'b0 || reg_write !== 1'b1) begin
      errors++; $display("FAIL ill_clear got ill=%0b rw=%0b exp 0,1", illegal, reg_write); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vec [4];
    logic [31:0] pcs [4];
    int idx = 0;
    int got = 0;
    logic fire_in;
    logic fire_out;
    for (int k = 0; k < 4; k++) begin
      vec[k] = {12'(k), 5'd0, 3'b000, 5'(10 + k), 7'b0010011};
      pcs[k] = 32'h0000_0800 + 32'(k * 4);
    end
    // drain anything still held
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 1 && cyc <= 3) ? 1'b0 : 1'b1;
      in_valid  = (idx < 4);
      instr     = (idx < 4) ? vec[idx] : 32'h0;
      pc        = (idx < 4) ? pcs[idx] : 32'h0;
      #1;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (cyc >= 1 && cyc <= 3) begin
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_out !== pcs[0] || rd !== 5'd10) begin
          errors++; $display("FAIL b2b_stall[%0d] got rdy=%0b v=%0b pc=%08h rd=%0d exp 0,1,%08h,10",
                             cyc, in_ready, out_valid, pc_out, rd, pcs[0]); end
      end
      if (fire_out) begin
        $display("b2b consumed pc=%08h rd=%0d", pc_out, rd);
        checks++; if (pc_out !== pcs[got] || rd !== 5'(10 + got)) begin
          errors++; $display("FAIL b2b_order[%0d] got pc=%08h rd=%0d exp %08h,%0d",
                             got, pc_out, rd, pcs[got], 10 + got); end
        got++;
      end
      @(posedge clk);
      if (fire_in) idx++;
    end
    in_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", got); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    // hold a beat with out_ready low
    @(negedge clk);
    in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h0000_0900; out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %0b exp 1", out_valid); end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h402081B3; pc = 32'h0000_0904;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", in_ready); end
    @(posedge clk);
    #1;
    $display("flush -> valid=%0b pc_out=%08h", out_valid, pc_out);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b exp 0", out_valid); end
    checks++; if (pc_out !== 32'h0000_0900 || alu_ctrl !== 4'h0) begin
      errors++; $display("FAIL flush_no_capture got pc=%08h alu=%0h exp 00000900,0", pc_out, alu_ctrl); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_valid = 1'b1; instr = 32'hFFC12283; pc = 32'h0000_0A00; out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || mem_read !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got v=%0b mr=%0b exp 1,1", out_valid, mem_read); end
    @(negedge clk);
    rst_n = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %0b exp 0", in_ready); end
    @(posedge clk);
    #1;
    $display("reset mid-stream -> valid=%0b pc_out=%08h imm=%08h", out_valid, pc_out, imm);
    checks++; if (out_valid !== 1'b0 || pc_out !== 32'h0 || imm !== 32'h0) begin
      errors++; $display("FAIL rstmid_clear got v=%0b pc=%08h imm=%08h exp 0,0,0", out_valid, pc_out, imm); end
    checks++; if (mem_read !== 1'b0 || reg_write !== 1'b0 || rd !== 5'd0 || rs1 !== 5'd0 || op_b_sel !== 1'b0) begin
      errors++; $display("FAIL rstmid_fields got mr=%0b rw=%0b rd=%0d rs1=%0d b=%0b exp 0", mem_read, reg_write, rd, rs1, op_b_sel); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_op_map;
    test_srai;
    test_upper;
    test_mem;
    test_branch;
    test_illegal;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
